// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer states; the encoding is visible on the state port.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_WAIT = 2'd2
    } state_e;

    // Default number of MEM_WAIT cycles without dmem_ready before bus_err.
    localparam int DMEM_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up on inc, hold at all-ones, clear has priority.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: merges load-use and branch hazards with
// multi-cycle data-memory and MDU waits, drives stage enables/flushes,
// counts stalled cycles and flags data-memory timeouts.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEFAULT,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_stall,
    input  logic             br_flush,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    input  logic             mdu_start_EX,
    input  logic             mdu_done,
    output logic             en_PC,
    output logic             en_IF_ID,
    output logic             en_ID_EX,
    output logic             en_EX_MEM,
    output logic             en_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             flush_MEM_WB,
    output logic [1:0]       state,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                WAIT_W    = $clog2(DMEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);

    state_e            state_q;
    state_e            state_n;
    logic              mdu_busy;
    logic              done_pend;
    logic [WAIT_W-1:0] wait_cnt;

    logic mem_miss;
    logic mdu_stall;

    assign mem_miss  = dmem_req_MEM & ~dmem_ready;
    assign mdu_stall = mdu_start_EX & ~mdu_done;
    assign state     = state_q;

    // Mealy enables/flushes and next state from current state and inputs.
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        state_n      = state_q;
        en_PC        = 1'b1;
        en_IF_ID     = 1'b1;
        en_ID_EX     = 1'b1;
        en_EX_MEM    = 1'b1;
        en_MEM_WB    = 1'b1;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        flush_MEM_WB = 1'b0;

        if (!rst_n) begin
            en_PC        = 1'b0;
            en_IF_ID     = 1'b0;
            en_ID_EX     = 1'b0;
            en_EX_MEM    = 1'b0;
            en_MEM_WB    = 1'b0;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            flush_MEM_WB = 1'b1;
            state_n      = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_miss) begin
                        // Freeze through EX/MEM, bubble into MEM/WB; hazards ignored.
                        en_PC        = 1'b0;
                        en_IF_ID     = 1'b0;
                        en_ID_EX     = 1'b0;
                        en_EX_MEM    = 1'b0;
                        flush_MEM_WB = 1'b1;
                        state_n      = MEM_WAIT;
                    end else if (mdu_stall) begin
                        // Freeze through ID/EX, bubble into EX/MEM, let MEM drain.
                        en_PC        = 1'b0;
                        en_IF_ID     = 1'b0;
                        en_ID_EX     = 1'b0;
                        flush_EX_MEM = 1'b1;
                        state_n      = MDU_WAIT;
                    end else if (br_flush) begin
                        // Squash the two wrong-path instructions; branch beats ld_stall.
                        flush_IF_ID = 1'b1;
                        flush_ID_EX = 1'b1;
                    end else if (ld_stall) begin
                        en_PC       = 1'b0;
                        en_IF_ID    = 1'b0;
                        flush_ID_EX = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        en_PC        = 1'b0;
                        en_IF_ID     = 1'b0;
                        en_ID_EX     = 1'b0;
                        en_EX_MEM    = 1'b0;
                        flush_MEM_WB = 1'b1;
                    end else if (mdu_busy && !done_pend) begin
                        state_n = MDU_WAIT;
                    end else begin
                        state_n = RUN;
                    end
                end
                MDU_WAIT: begin
                    if (!mdu_done) begin
                        en_PC        = 1'b0;
                        en_IF_ID     = 1'b0;
                        en_ID_EX     = 1'b0;
                        flush_EX_MEM = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    // State register, MDU bookkeeping flags and the memory timeout watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            mdu_busy  <= 1'b0;
            done_pend <= 1'b0;
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
        end else begin
            state_q <= state_n;

            // An MDU op may start while MEM is stalled; remember it is in flight.
            if (mdu_done) begin
                mdu_busy <= 1'b0;
            end else if (mdu_start_EX && (state_q != MDU_WAIT)) begin
                mdu_busy <= 1'b1;
            end

            // A done pulse seen while frozen on memory means no MDU wait afterwards.
            if (state_q == MEM_WAIT) begin
                if (dmem_ready) begin
                    done_pend <= 1'b0;
                end else if (mdu_done) begin
                    done_pend <= 1'b1;
                end
            end

            // Count MEM_WAIT cycles; hold at the last value so it never wraps.
            if ((state_q == RUN) && mem_miss) begin
                wait_cnt <= '0;
            end else if ((state_q == MEM_WAIT) && (wait_cnt != WAIT_LAST)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if ((state_q == MEM_WAIT) && !dmem_ready && (wait_cnt == WAIT_LAST)) begin
                bus_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .inc   (~en_PC),
        .clr   (~rst_n),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vector table, a long MDU sequence,
// then random stimulus against a behavioural model of the sequencing rules.
module tb_pipe_stall_ctrl;

    localparam int T     = 4;
    localparam int CNT_W = 5;
    localparam int MAXC  = (1 << CNT_W) - 1;

    // Stimulus bits, MSB first: rst_n, ld, br, req, ready, start, done.
    typedef struct packed {
        logic rst_n;
        logic ld;
        logic br;
        logic rq;
        logic rd;
        logic ms;
        logic md;
    } in_t;

    typedef struct {
        logic [4:0] en;   // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}
        logic [3:0] fl;   // {IF_ID, ID_EX, EX_MEM, MEM_WB}
        logic [1:0] st;
        logic       err;
        int         cnt;
    } obs_t;

    typedef struct {
        in_t  s;
        obs_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, ld_stall, br_flush, dmem_req_MEM, dmem_ready, mdu_start_EX, mdu_done;
    logic en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
    logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
    logic [1:0] state;
    logic bus_err;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which pipeline wait is outstanding, plus bookkeeping.
    bit m_mem, m_mdu, m_busy, m_pend, m_err;
    int m_k, m_stalls;

    vec_t tbl[$];

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .DMEM_TIMEOUT (T),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_stall     (ld_stall),
        .br_flush     (br_flush),
        .dmem_req_MEM (dmem_req_MEM),
        .dmem_ready   (dmem_ready),
        .mdu_start_EX (mdu_start_EX),
        .mdu_done     (mdu_done),
        .en_PC        (en_PC),
        .en_IF_ID     (en_IF_ID),
        .en_ID_EX     (en_ID_EX),
        .en_EX_MEM    (en_EX_MEM),
        .en_MEM_WB    (en_MEM_WB),
        .flush_IF_ID  (flush_IF_ID),
        .flush_ID_EX  (flush_ID_EX),
        .flush_EX_MEM (flush_EX_MEM),
        .flush_MEM_WB (flush_MEM_WB),
        .state        (state),
        .bus_err      (bus_err),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [6:0] s, input logic [4:0] en, input logic [3:0] fl,
                               input logic [1:0] st, input logic err, input int cnt);
        vec_t r;
        r.s     = in_t'(s);
        r.e.en  = en;
        r.e.fl  = fl;
        r.e.st  = st;
        r.e.err = err;
        r.e.cnt = cnt;
        return r;
    endfunction

    // The stall point is the first stage register that receives a bubble;
    // every stage before it holds, every stage from it onwards loads.
    task automatic model_predict(input in_t s, output logic [4:0] en, output logic [3:0] fl,
                                 output logic [1:0] st);
        int b;
        bit br;
        b  = 0;
        br = 0;
        en = '0;
        fl = '1;
        if (s.rst_n) begin
            if (m_mdu)                b = s.md ? 0 : 3;
            else if (m_mem)           b = s.rd ? 0 : 4;
            else if (s.rq && !s.rd)   b = 4;
            else if (s.ms && !s.md)   b = 3;
            else if (s.br)            br = 1;
            else if (s.ld)            b = 2;
            for (int k = 0; k < 5; k++) en[4-k] = (k >= b);
            for (int k = 1; k < 5; k++) fl[4-k] = (k == b) || (br && k <= 2);
        end
        st = m_mem ? 2'd1 : (m_mdu ? 2'd2 : 2'd0);
    endtask

    task automatic model_advance(input in_t s, input logic pc_en);
        bit old_busy, old_pend;
        if (!s.rst_n) begin
            m_mem = 0; m_mdu = 0; m_busy = 0; m_pend = 0; m_err = 0; m_k = 0; m_stalls = 0;
            return;
        end
        if (!pc_en) m_stalls = (m_stalls >= MAXC) ? MAXC : m_stalls + 1;
        old_busy = m_busy;
        old_pend = m_pend;
        if (s.md)                 m_busy = 0;
        else if (s.ms && !m_mdu)  m_busy = 1;
        if (m_mem) begin
            m_k++;
            if (!s.rd) begin
                if (m_k >= T) m_err = 1;
                if (s.md) m_pend = 1;
            end else begin
                m_pend = 0;
                m_mem  = 0;
                m_mdu  = old_busy && !old_pend;
            end
        end else if (m_mdu) begin
            if (s.md) m_mdu = 0;
        end else if (s.rq && !s.rd) begin
            m_mem = 1;
            m_k   = 0;
        end else if (s.ms && !s.md) begin
            m_mdu = 1;
        end
    endtask

    // Apply one cycle of stimulus, check mid-cycle against the model, step the model.
    task automatic drive_cycle(input in_t s, output obs_t o);
        logic [4:0] p_en;
        logic [3:0] p_fl;
        logic [1:0] p_st;
        rst_n        = s.rst_n;
        ld_stall     = s.ld;
        br_flush     = s.br;
        dmem_req_MEM = s.rq;
        dmem_ready   = s.rd;
        mdu_start_EX = s.ms;
        mdu_done     = s.md;
        @(negedge clk);
        o.en  = {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB};
        o.fl  = {flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB};
        o.st  = state;
        o.err = bus_err;
        o.cnt = int'(stall_cycles);
        model_predict(s, p_en, p_fl, p_st);
        check("model_en",    32'(o.en),  32'(p_en));
        check("model_flush", 32'(o.fl),  32'(p_fl));
        check("model_state", 32'(o.st),  32'(p_st));
        check("model_err",   32'(o.err), 32'(m_err));
        check("model_cnt",   32'(o.cnt), 32'(m_stalls));
        @(posedge clk);
        model_advance(s, p_en[4]);
        #1;
    endtask

    initial begin
        obs_t o;
        in_t  s;
        int   fl_exmem;
        bit   mwb_ok;

        //           r l b q d s m  en       flush    st err cnt
        tbl.push_back(v(7'b0000000, 5'b00000, 4'b1111, 0, 0, 0));
        tbl.push_back(v(7'b1000000, 5'b11111, 4'b0000, 0, 0, 0));
        tbl.push_back(v(7'b1100000, 5'b00111, 4'b0100, 0, 0, 0));  // ld_stall
        tbl.push_back(v(7'b1000000, 5'b11111, 4'b0000, 0, 0, 1));
        tbl.push_back(v(7'b1110000, 5'b11111, 4'b1100, 0, 0, 1));  // ld + br
        tbl.push_back(v(7'b1000000, 5'b11111, 4'b0000, 0, 0, 1));
        tbl.push_back(v(7'b1010000, 5'b11111, 4'b1100, 0, 0, 1));  // br alone
        tbl.push_back(v(7'b0000000, 5'b00000, 4'b1111, 0, 0, 1));
        tbl.push_back(v(7'b1111000, 5'b00001, 4'b0001, 0, 0, 0));  // miss, hazards ignored
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 1, 0, 1));
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 1, 0, 2));
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 1, 0, 3));
        tbl.push_back(v(7'b1001100, 5'b11111, 4'b0000, 1, 0, 4));  // ready
        tbl.push_back(v(7'b1000000, 5'b11111, 4'b0000, 0, 0, 4));
        tbl.push_back(v(7'b1001010, 5'b00001, 4'b0001, 0, 0, 4));  // miss + mdu start
        tbl.push_back(v(7'b1001010, 5'b00001, 4'b0001, 1, 0, 5));
        tbl.push_back(v(7'b1001011, 5'b00001, 4'b0001, 1, 0, 6));  // done during MEM_WAIT
        tbl.push_back(v(7'b1001100, 5'b11111, 4'b0000, 1, 0, 7));
        tbl.push_back(v(7'b1000000, 5'b11111, 4'b0000, 0, 0, 7));  // back to RUN
        tbl.push_back(v(7'b1001010, 5'b00001, 4'b0001, 0, 0, 7));  // miss + mdu start
        tbl.push_back(v(7'b1001110, 5'b11111, 4'b0000, 1, 0, 8));  // ready, mdu pending
        tbl.push_back(v(7'b1000010, 5'b00011, 4'b0010, 2, 0, 8));
        tbl.push_back(v(7'b1000011, 5'b11111, 4'b0000, 2, 0, 9));
        tbl.push_back(v(7'b1000000, 5'b11111, 4'b0000, 0, 0, 9));
        tbl.push_back(v(7'b1000011, 5'b11111, 4'b0000, 0, 0, 9));  // start+done same cycle
        tbl.push_back(v(7'b1000000, 5'b11111, 4'b0000, 0, 0, 9));
        tbl.push_back(v(7'b0000000, 5'b00000, 4'b1111, 0, 0, 9));
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 0, 0, 0));  // timeout run
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 1, 0, 1));
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 1, 0, 2));
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 1, 0, 3));
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 1, 0, 4));
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 1, 1, 5));
        tbl.push_back(v(7'b1001100, 5'b11111, 4'b0000, 1, 1, 6));
        tbl.push_back(v(7'b1000000, 5'b11111, 4'b0000, 0, 1, 6));  // sticky
        tbl.push_back(v(7'b0000000, 5'b00000, 4'b1111, 0, 1, 6));
        tbl.push_back(v(7'b1000000, 5'b11111, 4'b0000, 0, 0, 0));
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 0, 0, 0));  // reset mid-wait
        tbl.push_back(v(7'b1001000, 5'b00001, 4'b0001, 1, 0, 1));
        tbl.push_back(v(7'b0001000, 5'b00000, 4'b1111, 1, 0, 2));
        tbl.push_back(v(7'b1000000, 5'b11111, 4'b0000, 0, 0, 0));

        rst_n = 1'b0; ld_stall = 1'b0; br_flush = 1'b0; dmem_req_MEM = 1'b0;
        dmem_ready = 1'b0; mdu_start_EX = 1'b0; mdu_done = 1'b0;
        model_advance(in_t'(7'b0), 1'b0);
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive_cycle(tbl[i].s, o);
            check($sformatf("tbl%0d_en", i),    32'(o.en),  32'(tbl[i].e.en));
            check($sformatf("tbl%0d_flush", i), 32'(o.fl),  32'(tbl[i].e.fl));
            check($sformatf("tbl%0d_state", i), 32'(o.st),  32'(tbl[i].e.st));
            check($sformatf("tbl%0d_err", i),   32'(o.err), 32'(tbl[i].e.err));
            check($sformatf("tbl%0d_cnt", i),   32'(o.cnt), 32'(tbl[i].e.cnt));
        end

        // Long MDU op: 33 stalled cycles, done on the 34th; counter saturates.
        fl_exmem = 0;
        mwb_ok   = 1;
        for (int c = 0; c < 33; c++) begin
            drive_cycle(in_t'(7'b1000010), o);
            check($sformatf("mdu_state_%0d", c), 32'(o.st), (c == 0) ? 32'd0 : 32'd2);
            fl_exmem += int'(o.fl[1]);
            if (!o.en[0]) mwb_ok = 0;
        end
        drive_cycle(in_t'(7'b1000011), o);
        check("mdu_done_en",    32'(o.en), 32'b11111);
        check("mdu_done_state", 32'(o.st), 32'd2);
        if (!o.en[0]) mwb_ok = 0;
        drive_cycle(in_t'(7'b1000000), o);
        check("mdu_after_state", 32'(o.st),  32'd0);
        check("mdu_sat_cnt",     32'(o.cnt), 32'(MAXC));
        check("mdu_flush_cycles", 32'(fl_exmem), 32'd33);
        check("mdu_en_mem_wb",   32'(mwb_ok), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            s.rst_n = ($urandom_range(0, 59) != 0);
            s.ld    = ($urandom_range(0, 3) == 0);
            s.br    = ($urandom_range(0, 4) == 0);
            s.rq    = ($urandom_range(0, 2) == 0);
            s.rd    = ($urandom_range(0, 3) == 0);
            s.ms    = ($urandom_range(0, 4) == 0);
            s.md    = ($urandom_range(0, 7) == 0);
            drive_cycle(s, o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
